// File: rtl/axi_sram_slave_if.sv
// AXI4-Lite style bus bundle for the SRAM slave: AW/W/B write path and AR/R read path.
interface axi_sram_slave_if #(
    parameter int ADDR_W = 32
);
    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic              wvalid;
    logic              wready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic              rvalid;
    logic              rready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi_sram_slave.sv
// Single-outstanding AXI-Lite SRAM slave with programmable read/write wait states.
module axi_sram_slave #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 1024,
    parameter int RD_LAT = 1,
    parameter int WR_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    axi_sram_slave_if.slave    io_slave
);
    localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int CNT_W   = (MAX_LAT > 0) ? $clog2(MAX_LAT + 1) : 1;
    localparam int IDX_W   = ADDR_W - 2;
    localparam int MIDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W:0] DEPTH_W = (IDX_W + 1)'(DEPTH);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR_WAIT = 3'd1;
    localparam logic [2:0] WR_RESP = 3'd2;
    localparam logic [2:0] RD_WAIT = 3'd3;
    localparam logic [2:0] RD_RESP = 3'd4;

    logic [2:0]       state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [IDX_W-1:0] addr_q,   addr_d;
    logic [31:0]      wdata_q,  wdata_d;
    logic [3:0]       wstrb_q,  wstrb_d;
    logic             bvalid_q, bvalid_d;
    logic [1:0]       bresp_q,  bresp_d;
    logic             rvalid_q, rvalid_d;
    logic [1:0]       rresp_q,  rresp_d;
    logic [31:0]      rdata_q,  rdata_d;

    logic [31:0]       mem_q [DEPTH];
    logic [MIDX_W-1:0] midx;
    logic              in_range;
    logic              wr_req;
    logic              aw_acc;
    logic              ar_acc;
    logic              wr_en;
    logic [31:0]       rd_word;
    logic [3:0]        unused_addr_lsb;

    assign unused_addr_lsb = {io_slave.awaddr[1:0], io_slave.araddr[1:0]};

    assign midx     = addr_q[MIDX_W-1:0];
    assign in_range = ({1'b0, addr_q} < DEPTH_W);
    assign rd_word  = mem_q[midx];

    // Readies are gated by rst so nothing can be accepted while reset is held.
    assign wr_req = io_slave.awvalid & io_slave.wvalid;
    assign aw_acc = (state_q == IDLE) & wr_req & ~rst;
    assign ar_acc = (state_q == IDLE) & io_slave.arvalid & ~wr_req & ~rst;

    assign io_slave.awready = aw_acc;
    assign io_slave.wready  = aw_acc;
    assign io_slave.arready = ar_acc;
    assign io_slave.bvalid  = bvalid_q;
    assign io_slave.bresp   = bresp_q;
    assign io_slave.rvalid  = rvalid_q;
    assign io_slave.rresp   = rresp_q;
    assign io_slave.rdata   = rdata_q;

    assign wr_en = (state_q == WR_WAIT) & (cnt_q == '0) & in_range & ~rst;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;
        rvalid_d = rvalid_q;
        rresp_d  = rresp_q;
        rdata_d  = rdata_q;
        case (state_q)
            IDLE: begin
                if (aw_acc) begin
                    addr_d  = io_slave.awaddr[ADDR_W-1:2];
                    wdata_d = io_slave.wdata;
                    wstrb_d = io_slave.wstrb;
                    cnt_d   = CNT_W'(WR_LAT);
                    state_d = WR_WAIT;
                end else if (ar_acc) begin
                    addr_d  = io_slave.araddr[ADDR_W-1:2];
                    cnt_d   = CNT_W'(RD_LAT);
                    state_d = RD_WAIT;
                end
            end
            WR_WAIT: begin
                if (cnt_q == '0) begin
                    state_d  = WR_RESP;
                    bvalid_d = 1'b1;
                    bresp_d  = in_range ? 2'b00 : 2'b11;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WR_RESP: begin
                if (io_slave.bready) begin
                    bvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            RD_WAIT: begin
                if (cnt_q == '0) begin
                    state_d  = RD_RESP;
                    rvalid_d = 1'b1;
                    rdata_d  = in_range ? rd_word : 32'h0;
                    rresp_d  = in_range ? 2'b00 : 2'b11;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RD_RESP: begin
                if (io_slave.rready) begin
                    rvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bvalid_q <= 1'b0;
            bresp_q  <= 2'b00;
            rvalid_q <= 1'b0;
            rresp_q  <= 2'b00;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            bvalid_q <= bvalid_d;
            bresp_q  <= bresp_d;
            rvalid_q <= rvalid_d;
            rresp_q  <= rresp_d;
            rdata_q  <= rdata_d;
        end
    end

    // Storage has no reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (wstrb_q[b]) mem_q[midx][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end
endmodule

// File: doc/axi_sram_slave.md
AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 32, address width; DEPTH, default 1024, number of 32-bit words; RD_LAT, default 1, read wait cycles; WR_LAT, default 1, write wait cycles.
REQ-002 clk  in  1  single clock; all logic on the rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 io_slave_awvalid/awready  in/out  1/1  write-address handshake; io_slave_awaddr  in  ADDR_W  byte address.
REQ-005 io_slave_wvalid/wready  in/out  1/1  write-data handshake; io_slave_wdata  in  32; io_slave_wstrb  in  4  byte enables.
REQ-006 io_slave_bvalid  out  1; io_slave_bready  in  1; io_slave_bresp  out  2  write response.
REQ-007 io_slave_arvalid/arready  in/out  1/1  read-address handshake; io_slave_araddr  in  ADDR_W.
REQ-008 io_slave_rvalid  out  1; io_slave_rready  in  1; io_slave_rdata  out  32; io_slave_rresp  out  2.

Function
REQ-009 The FSM SHALL have five states: IDLE, WR_WAIT, WR_RESP, RD_WAIT, RD_RESP; exactly one transaction is in flight at a time.
REQ-010 In IDLE, awready and wready SHALL both be 1 only when awvalid and wvalid are both 1, so AW and W are accepted in the same cycle; otherwise both are 0.
REQ-011 In IDLE, arready SHALL be 1 only when arvalid=1 and the write pair (awvalid&wvalid) is not also pending; writes have priority on simultaneous requests.
REQ-012 All ready outputs SHALL be 0 in every state other than IDLE.
REQ-013 On acceptance, the block SHALL latch the address, wdata and wstrb, load a wait counter with WR_LAT or RD_LAT, and enter WR_WAIT or RD_WAIT.
REQ-014 In a WAIT state the counter SHALL decrement each cycle; when the counter is 0 the FSM SHALL move to the matching RESP state.
REQ-015 With latency 0, the RESP state SHALL be entered on the cycle after acceptance.
REQ-016 With latency N, the response valid SHALL assert exactly N+1 cycles after the acceptance edge.
REQ-017 Word index SHALL be addr[ADDR_W-1:2]; addr[1:0] SHALL be ignored (no misalignment error).
REQ-018 In-range condition: word index < DEPTH.
REQ-019 An in-range write SHALL update only the bytes whose wstrb bit is 1, on the WR_WAIT->WR_RESP transition; bresp SHALL be 2'b00.
REQ-020 An out-of-range write SHALL leave memory unchanged; bresp SHALL be 2'b11.
REQ-021 An in-range read SHALL drive rdata with the word value at the RD_WAIT->RD_RESP transition; rresp SHALL be 2'b00.
REQ-022 An out-of-range read SHALL drive rdata=32'h0 and rresp=2'b11.
REQ-023 bvalid/rvalid, bresp, rresp and rdata SHALL be registered and held stable until the corresponding ready is sampled 1.
REQ-024 The FSM SHALL return to IDLE on the cycle after a bvalid&bready or rvalid&rready handshake.
REQ-025 The next request SHALL be accepted no earlier than that IDLE cycle (no back-to-back overlap).
REQ-026 A write followed by a read of the same word SHALL return the newly written data.

Reset
REQ-027 While rst=1 at a clock edge, the FSM SHALL go to IDLE and the counter SHALL clear.
REQ-028 On reset, all valid and ready outputs SHALL be 0, bresp/rresp SHALL be 2'b00, and rdata SHALL be 32'h0.
REQ-029 Reset asserted mid-transaction SHALL abort the transaction with no response issued.
REQ-030 A write aborted by reset before WR_RESP SHALL not modify memory.
REQ-031 Memory contents SHALL not be cleared by reset.

Verification
REQ-032 Write/read with WR_LAT=RD_LAT=1: write addr 0x10, data 0xDEADBEEF, wstrb 4'hF, bready=1 -> bvalid 2 cycles after accept, bresp 00; then read 0x10 -> rdata 0xDEADBEEF, rresp 00.
REQ-033 Partial strobe: word 0x10 = 0xDEADBEEF, write 0x11223344 with wstrb 4'b0101 -> subsequent read returns 0xDE22BE44.
REQ-034 Simultaneous AW+W and AR in IDLE -> write accepted first, arready=0 that cycle; the read is accepted in the IDLE cycle after the b handshake.
REQ-035 Backpressure: rready held 0 for 5 cycles -> rvalid and rdata remain stable throughout; handshake on the 6th cycle, then IDLE.
REQ-036 Out-of-range: write to word DEPTH -> bresp 11, memory unchanged; read of word DEPTH -> rdata 0, rresp 11.
REQ-037 Reset during WR_WAIT -> bvalid never asserts and the target word keeps its old value; the next cycle after reset release is IDLE with all readys 0.
